// File: rtl/pc_top_pkg.sv
// Shared definitions for next-PC selection: control-word bit positions and
// the PCSRC source encodings.
package pc_top_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned JTA_W    = 26;
  localparam int unsigned SYSC_W   = 30;
  localparam int unsigned CTRL_W   = 22;

  localparam int unsigned JUMPADDR = 21;
  localparam int unsigned PCSRC_HI = 20;
  localparam int unsigned PCSRC_LO = 19;

  typedef enum logic [1:0] {
    PCSRC_JUMP = 2'b00,
    PCSRC_XREG = 2'b01,
    PCSRC_ZREG = 2'b10,
    PCSRC_ALU  = 2'b11
  } pcsrc_e;

endpackage

// File: rtl/pc_top_reg32.sv
// 32-bit register with asynchronous active-high clear; used for Z and
// reusable elsewhere in the datapath.
module reg32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pc_top.sv
// Next-PC source selection: jump target / X / Z / ALU mux, plus the Z
// register that captures the ALU result every cycle.
module pc_top
  import pc_top_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic [31:0] x_reg_out,
  input  logic [25:0] jta,
  input  logic [31:0] pc,
  input  logic [29:0] syscall,
  input  logic [21:0] ctrl_in,
  output logic [31:0] pc_src,
  output logic [31:0] z_reg_out
);

  logic [31:0] jump_target;
  logic [31:0] z_q;
  pcsrc_e      pcsrc;

  reg32 u_z_reg (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (alu_out),
    .q_o   (z_q)
  );

  assign z_reg_out = z_q;

  always_comb begin
    jump_target = '0;
    if (ctrl_in[JUMPADDR]) begin
      jump_target = {syscall, 2'b00};
    end else begin
      jump_target = {pc[31:28], jta, 2'b00};
    end
  end

  always_comb begin
    pcsrc  = pcsrc_e'(ctrl_in[PCSRC_HI:PCSRC_LO]);
    pc_src = jump_target;
    case (pcsrc)
      PCSRC_JUMP: pc_src = jump_target;
      PCSRC_XREG: pc_src = x_reg_out;
      PCSRC_ZREG: pc_src = z_q;
      PCSRC_ALU:  pc_src = alu_out;
      default:    pc_src = jump_target;
    endcase
  end

  // Low control bits and PC low bits belong to other datapath blocks.
  logic unused_bits;
  assign unused_bits = ^{ctrl_in[18:0], pc[27:0]};

endmodule

// File: tb/tb_pc_top.sv
// Directed self-checking bench for pc_top.
module tb_pc_top;

  logic        clk;
  logic        reset;
  logic [31:0] alu_out;
  logic [31:0] x_reg_out;
  logic [25:0] jta;
  logic [31:0] pc;
  logic [29:0] syscall;
  logic [21:0] ctrl_in;
  logic [31:0] pc_src;
  logic [31:0] z_reg_out;

  int unsigned checks;
  int unsigned errors;

  pc_top dut (
    .clk       (clk),
    .reset     (reset),
    .alu_out   (alu_out),
    .x_reg_out (x_reg_out),
    .jta       (jta),
    .pc        (pc),
    .syscall   (syscall),
    .ctrl_in   (ctrl_in),
    .pc_src    (pc_src),
    .z_reg_out (z_reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] ctrl(input logic ja, input logic [1:0] src, input logic [18:0] low);
    return {ja, src, low};
  endfunction

  logic [18:0] low_pats [4];

  initial begin
    checks    = 0;
    errors    = 0;
    pc        = 32'h1000_0000;
    syscall   = 30'h3FFF_FFFF;
    x_reg_out = '0;
    jta       = '0;
    alu_out   = 32'hFFFF_FFFF;
    ctrl_in   = ctrl(1'b0, 2'b10, 19'h0);
    reset     = 1'b1;
    low_pats[0] = 19'h7FFFF;
    low_pats[1] = 19'h55555;
    low_pats[2] = 19'h2AAAA;
    low_pats[3] = 19'h00001;

    // 1: reset holds Z at zero while alu_out toggles
    #1;
    check("rst_z", z_reg_out, 32'h0);
    check("rst_pcsrc_z", pc_src, 32'h0);
    for (int i = 0; i < 3; i++) begin
      alu_out = ~alu_out;
      step();
      check("rst_hold_z", z_reg_out, 32'h0);
    end
    reset   = 1'b0;
    alu_out = 32'hA5A5_0001;
    #1;
    check("rst_release_no_edge", z_reg_out, 32'h0);
    step();
    check("first_load", z_reg_out, 32'hA5A5_0001);

    // 2: jump target from pc/jta
    ctrl_in = ctrl(1'b0, 2'b00, 19'h0);
    jta     = 26'h3FFFFFF;
    #1;
    check("jump_jta_all1", pc_src, 32'h1FFF_FFFC);
    jta = 26'h03FFFFF;
    #1;
    check("jump_jta", pc_src, 32'h10FF_FFFC);
    jta = 26'h0;
    #1;
    check("jump_jta_zero", pc_src, 32'h1000_0000);

    // 3: syscall target ignores jta
    ctrl_in = ctrl(1'b1, 2'b00, 19'h0);
    #1;
    check("jump_syscall", pc_src, 32'hFFFF_FFFC);
    jta = 26'h0123456;
    #1;
    check("jump_syscall_jta_chg", pc_src, 32'hFFFF_FFFC);
    syscall = 30'h0000_0401;
    #1;
    check("jump_syscall_small", pc_src, 32'h0000_1004);
    syscall = 30'h3FFF_FFFF;

    // 4: X register, combinational
    ctrl_in   = ctrl(1'b0, 2'b01, 19'h0);
    x_reg_out = 32'h1234_5678;
    #1;
    check("xreg", pc_src, 32'h1234_5678);
    x_reg_out = 32'h8765_4321;
    #1;
    check("xreg_chg", pc_src, 32'h8765_4321);

    // 5: Z path shows old value until the edge
    alu_out = 32'h0BAD_F00D;
    step();
    check("z_load", z_reg_out, 32'h0BAD_F00D);
    ctrl_in = ctrl(1'b0, 2'b10, 19'h0);
    alu_out = 32'hDEAD_BEEF;
    #1;
    check("zreg_old_pcsrc", pc_src, 32'h0BAD_F00D);
    check("zreg_old_z", z_reg_out, 32'h0BAD_F00D);
    step();
    check("zreg_new_z", z_reg_out, 32'hDEAD_BEEF);
    check("zreg_new_pcsrc", pc_src, 32'hDEAD_BEEF);

    // 6: ALU path and ctrl_in[18:0] independence
    ctrl_in = ctrl(1'b0, 2'b11, 19'h0);
    alu_out = 32'hCAFE_BABE;
    #1;
    check("alu_pcsrc", pc_src, 32'hCAFE_BABE);
    check("alu_z_before", z_reg_out, 32'hDEAD_BEEF);
    step();
    check("alu_z_after", z_reg_out, 32'hCAFE_BABE);
    for (int i = 0; i < 4; i++) begin
      ctrl_in = ctrl(1'b0, 2'b11, low_pats[i]);
      #1;
      check("low_ctrl_alu", pc_src, 32'hCAFE_BABE);
      ctrl_in = ctrl(1'b1, 2'b00, low_pats[i]);
      #1;
      check("low_ctrl_jump", pc_src, 32'hFFFF_FFFC);
      check("low_ctrl_z", z_reg_out, 32'hCAFE_BABE);
    end

    // Mid-operation reset clears Z without a clock edge
    ctrl_in = ctrl(1'b0, 2'b10, 19'h0);
    #1;
    check("pre_rst_pcsrc", pc_src, 32'hCAFE_BABE);
    reset = 1'b1;
    #1;
    check("midrst_z", z_reg_out, 32'h0);
    check("midrst_pcsrc", pc_src, 32'h0);
    step();
    check("midrst_hold", z_reg_out, 32'h0);
    #2;
    reset = 1'b0;
    step();
    check("post_midrst_load", z_reg_out, 32'hCAFE_BABE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
